// File: rtl/ex_stage_exmem.sv
// Execute stage of the 5-stage RV64 core together with the EX/MEM pipeline register.
// Forwards operands from EX/MEM and MEM/WB, runs the ALU, resolves branches,
// and raises a one-cycle flush toward IF/ID and ID/EX when a branch is taken.
module ex_stage_exmem #(
    parameter int XLEN  = 64,
    parameter int RADDR = 5
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             stall,
    input  logic             branch,
    input  logic             memwrite,
    input  logic             memread,
    input  logic             memtoreg,
    input  logic             alusrc,
    input  logic             regwrite,
    input  logic [1:0]       ALUop,
    input  logic [XLEN-1:0]  PC,
    input  logic [XLEN-1:0]  RD1,
    input  logic [XLEN-1:0]  RD2,
    input  logic [XLEN-1:0]  Immgen,
    input  logic [3:0]       func,
    input  logic [2:0]       func3,
    input  logic [RADDR-1:0] RD,
    input  logic [RADDR-1:0] rd1,
    input  logic [RADDR-1:0] rd2,
    input  logic             wb_regwrite,
    input  logic [RADDR-1:0] wb_rd,
    input  logic [XLEN-1:0]  wb_data,
    output logic             exmem_regwrite,
    output logic             exmem_memtoreg,
    output logic             exmem_memread,
    output logic             exmem_memwrite,
    output logic [XLEN-1:0]  exmem_alu,
    output logic [XLEN-1:0]  exmem_store,
    output logic [RADDR-1:0] exmem_rd,
    output logic [XLEN-1:0]  exmem_target,
    output logic             flush
);

    logic signed [XLEN-1:0] fwd_a;
    logic signed [XLEN-1:0] fwd_b;
    logic signed [XLEN-1:0] op_b;
    logic        [XLEN-1:0] alu_res;
    logic                   taken;

    // ALU: immediate forms share the register encodings except SRAI keeps func[3]
    function automatic logic [XLEN-1:0] alu_op(
        input logic [1:0]             op,
        input logic [3:0]             fn,
        input logic                   imm,
        input logic signed [XLEN-1:0] a,
        input logic signed [XLEN-1:0] b
    );
        logic [3:0]      code;
        logic [5:0]      sh;
        logic [XLEN-1:0] r;
        code = fn;
        if (imm && fn != 4'b1101) code[3] = 1'b0;
        sh = b[5:0];
        r  = '0;
        case (op)
            2'b00: r = a + b;
            2'b01: r = a - b;
            2'b10: begin
                case (code)
                    4'b0000: r = a + b;
                    4'b1000: r = a - b;
                    4'b0111: r = a & b;
                    4'b0110: r = a | b;
                    4'b0100: r = a ^ b;
                    4'b0001: r = $unsigned(a) << sh;
                    4'b0101: r = $unsigned(a) >> sh;
                    4'b1101: r = a >>> sh;
                    4'b0010: r = {{(XLEN-1){1'b0}}, (a < b)};
                    4'b0011: r = {{(XLEN-1){1'b0}}, ($unsigned(a) < $unsigned(b))};
                    default: r = '0;
                endcase
            end
            default: r = '0;
        endcase
        return r;
    endfunction

    // Branch condition evaluated on the forwarded register operands
    function automatic logic br_cond(
        input logic [2:0]             f3,
        input logic signed [XLEN-1:0] a,
        input logic signed [XLEN-1:0] b
    );
        logic c;
        case (f3)
            3'b000:  c = (a == b);
            3'b001:  c = (a != b);
            3'b100:  c = (a < b);
            3'b101:  c = (a >= b);
            3'b110:  c = ($unsigned(a) < $unsigned(b));
            3'b111:  c = ($unsigned(a) >= $unsigned(b));
            default: c = 1'b0;
        endcase
        return c;
    endfunction

    // Operand forwarding: EX/MEM (non-load) beats MEM/WB beats register file; x0 never forwarded
    always_comb begin
        fwd_a = RD1;
        fwd_b = RD2;
        if (exmem_regwrite && !exmem_memread && exmem_rd != '0 && exmem_rd == rd1)
            fwd_a = exmem_alu;
        else if (wb_regwrite && wb_rd != '0 && wb_rd == rd1)
            fwd_a = wb_data;
        if (exmem_regwrite && !exmem_memread && exmem_rd != '0 && exmem_rd == rd2)
            fwd_b = exmem_alu;
        else if (wb_regwrite && wb_rd != '0 && wb_rd == rd2)
            fwd_b = wb_data;
        op_b    = alusrc ? Immgen : fwd_b;
        alu_res = alu_op(ALUop, func, alusrc, fwd_a, op_b);
        taken   = branch & br_cond(func3, fwd_a, fwd_b);
    end

    // ---- EX -> MEM boundary ----
    // EX/MEM register: squash to a bubble after a taken branch, otherwise hold on stall
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            exmem_regwrite <= 1'b0;
            exmem_memtoreg <= 1'b0;
            exmem_memread  <= 1'b0;
            exmem_memwrite <= 1'b0;
            exmem_alu      <= '0;
            exmem_store    <= '0;
            exmem_rd       <= '0;
            exmem_target   <= '0;
            flush          <= 1'b0;
        end else if (flush) begin
            exmem_regwrite <= 1'b0;
            exmem_memtoreg <= 1'b0;
            exmem_memread  <= 1'b0;
            exmem_memwrite <= 1'b0;
            exmem_alu      <= '0;
            exmem_store    <= '0;
            exmem_rd       <= '0;
            exmem_target   <= '0;
            flush          <= 1'b0;
        end else if (!stall) begin
            exmem_regwrite <= regwrite;
            exmem_memtoreg <= memtoreg;
            exmem_memread  <= memread;
            exmem_memwrite <= memwrite;
            exmem_alu      <= alu_res;
            exmem_store    <= fwd_b;
            exmem_rd       <= RD;
            exmem_target   <= PC + Immgen;
            flush          <= taken;
        end
    end

endmodule

// File: tb/tb_ex_stage_exmem.sv
// Self-checking bench for ex_stage_exmem: directed scenarios with literal
// expectations, then randomized traffic compared every cycle to a behavioural model.
module tb_ex_stage_exmem;
    localparam int XLEN  = 64;
    localparam int RADDR = 5;

    logic             clk = 1'b0;
    logic             reset_n = 1'b1;
    logic             stall, branch, memwrite, memread, memtoreg, alusrc, regwrite;
    logic [1:0]       ALUop;
    logic [XLEN-1:0]  PC, RD1, RD2, Immgen, wb_data;
    logic [3:0]       func;
    logic [2:0]       func3;
    logic [RADDR-1:0] RD, rd1, rd2, wb_rd;
    logic             wb_regwrite;
    logic             exmem_regwrite, exmem_memtoreg, exmem_memread, exmem_memwrite, flush;
    logic [XLEN-1:0]  exmem_alu, exmem_store, exmem_target;
    logic [RADDR-1:0] exmem_rd;

    int errors = 0;
    int checks = 0;

    ex_stage_exmem #(.XLEN(XLEN), .RADDR(RADDR)) dut (
        .clk(clk), .reset_n(reset_n), .stall(stall), .branch(branch),
        .memwrite(memwrite), .memread(memread), .memtoreg(memtoreg),
        .alusrc(alusrc), .regwrite(regwrite), .ALUop(ALUop), .PC(PC),
        .RD1(RD1), .RD2(RD2), .Immgen(Immgen), .func(func), .func3(func3),
        .RD(RD), .rd1(rd1), .rd2(rd2), .wb_regwrite(wb_regwrite),
        .wb_rd(wb_rd), .wb_data(wb_data),
        .exmem_regwrite(exmem_regwrite), .exmem_memtoreg(exmem_memtoreg),
        .exmem_memread(exmem_memread), .exmem_memwrite(exmem_memwrite),
        .exmem_alu(exmem_alu), .exmem_store(exmem_store), .exmem_rd(exmem_rd),
        .exmem_target(exmem_target), .flush(flush)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic        m_regwrite, m_memtoreg, m_memread, m_memwrite, m_flush;
    logic [63:0] m_alu, m_store, m_target;
    logic [4:0]  m_rd;

    function automatic string decode(input logic [1:0] op, input logic [3:0] fn, input logic imm);
        logic [3:0] k;
        if (op == 2'b00) return "ADD";
        if (op == 2'b01) return "SUB";
        if (op == 2'b11) return "NONE";
        k = (imm && fn != 4'b1101) ? {1'b0, fn[2:0]} : fn;
        case (k)
            4'b0000: return "ADD";
            4'b1000: return "SUB";
            4'b0111: return "AND";
            4'b0110: return "OR";
            4'b0100: return "XOR";
            4'b0001: return "SLL";
            4'b0101: return "SRL";
            4'b1101: return "SRA";
            4'b0010: return "SLT";
            4'b0011: return "SLTU";
            default: return "NONE";
        endcase
    endfunction

    function automatic logic [63:0] model_alu(input string m, input logic [63:0] a, input logic [63:0] b);
        longint sa, sb;
        int     sh;
        sa = a;
        sb = b;
        sh = int'(b[5:0]);
        if (m == "ADD")  return a + b;
        if (m == "SUB")  return a - b;
        if (m == "AND")  return a & b;
        if (m == "OR")   return a | b;
        if (m == "XOR")  return a ^ b;
        if (m == "SLL")  return a << sh;
        if (m == "SRL")  return a >> sh;
        if (m == "SRA")  return sa >>> sh;
        if (m == "SLT")  return (sa < sb) ? 64'd1 : 64'd0;
        if (m == "SLTU") return (a < b) ? 64'd1 : 64'd0;
        return 64'd0;
    endfunction

    function automatic bit model_taken(input logic [2:0] f3, input logic [63:0] a, input logic [63:0] b);
        longint sa, sb;
        sa = a;
        sb = b;
        case (f3)
            3'b000:  return a == b;
            3'b001:  return a != b;
            3'b100:  return sa < sb;
            3'b101:  return sa >= sb;
            3'b110:  return a < b;
            3'b111:  return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [63:0] model_fwd(input logic [4:0] src, input logic [63:0] rf);
        if (m_regwrite && !m_memread && m_rd != 0 && m_rd == src) return m_alu;
        if (wb_regwrite && wb_rd != 0 && wb_rd == src) return wb_data;
        return rf;
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n || m_flush) begin
            m_regwrite <= 0; m_memtoreg <= 0; m_memread <= 0; m_memwrite <= 0;
            m_alu <= 0; m_store <= 0; m_rd <= 0; m_target <= 0; m_flush <= 0;
        end else if (!stall) begin
            m_regwrite <= regwrite;
            m_memtoreg <= memtoreg;
            m_memread  <= memread;
            m_memwrite <= memwrite;
            m_alu      <= model_alu(decode(ALUop, func, alusrc), model_fwd(rd1, RD1),
                                    alusrc ? Immgen : model_fwd(rd2, RD2));
            m_store    <= model_fwd(rd2, RD2);
            m_rd       <= RD;
            m_target   <= PC + Immgen;
            m_flush    <= branch && model_taken(func3, model_fwd(rd1, RD1), model_fwd(rd2, RD2));
        end
    end

    // Compare every output against the model away from the active edge
    always @(negedge clk) begin
        chk("m_regwrite", exmem_regwrite, m_regwrite);
        chk("m_memtoreg", exmem_memtoreg, m_memtoreg);
        chk("m_memread",  exmem_memread,  m_memread);
        chk("m_memwrite", exmem_memwrite, m_memwrite);
        chk("m_alu",      exmem_alu,      m_alu);
        chk("m_store",    exmem_store,    m_store);
        chk("m_rd",       exmem_rd,       m_rd);
        chk("m_target",   exmem_target,   m_target);
        chk("m_flush",    flush,          m_flush);
    end

    // ---------------- stimulus ----------------
    task automatic nop();
        stall = 0; branch = 0; memwrite = 0; memread = 0; memtoreg = 0; alusrc = 0;
        regwrite = 0; ALUop = 2'b00; PC = 0; RD1 = 0; RD2 = 0; Immgen = 0;
        func = 0; func3 = 0; RD = 0; rd1 = 0; rd2 = 0;
        wb_regwrite = 0; wb_rd = 0; wb_data = 0;
    endtask

    task automatic edge_then_sample();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] pick();
        case ($urandom % 6)
            0: return 64'd0;
            1: return 64'd1;
            2: return 64'hFFFF_FFFF_FFFF_FFFF;
            3: return 64'h8000_0000_0000_0000;
            4: return 64'($urandom % 8);
            default: return {$urandom, $urandom};
        endcase
    endfunction

    initial begin
        nop();
        #1 reset_n = 0;
        repeat (2) @(negedge clk);
        chk("reset_alu", exmem_alu, 0);
        chk("reset_flush", flush, 0);
        chk("reset_regwrite", exmem_regwrite, 0);
        chk("reset_target", exmem_target, 0);

        // pin the model against hand-computed values
        chk("model_sra", model_alu("SRA", 64'hFFFF_FFFF_FFFF_FFF0, 64'd2), 64'hFFFF_FFFF_FFFF_FFFC);
        chk("model_slt", model_alu("SLT", 64'hFFFF_FFFF_FFFF_FFFF, 64'd1), 64'd1);
        chk("model_sltu", model_alu("SLTU", 64'hFFFF_FFFF_FFFF_FFFF, 64'd1), 64'd0);
        chk("model_addi", model_alu(decode(2'b10, 4'b1000, 1'b1), 64'd10, 64'd3), 64'd13);
        chk("model_srai", model_alu(decode(2'b10, 4'b1101, 1'b1), 64'h8000_0000_0000_0000, 64'd63),
            64'hFFFF_FFFF_FFFF_FFFF);
        reset_n = 1;

        // ADD 5+7 -> x3
        @(negedge clk); nop();
        RD1 = 5; RD2 = 7; ALUop = 2'b10; func = 4'b0000; RD = 3; regwrite = 1; rd1 = 1; rd2 = 2;
        edge_then_sample();
        chk("add_alu", exmem_alu, 12);
        chk("add_rd", exmem_rd, 3);
        chk("add_regwrite", exmem_regwrite, 1);

        // SUB with rs1 forwarded from EX/MEM
        @(negedge clk); nop();
        rd1 = 3; RD1 = 0; RD2 = 1; ALUop = 2'b10; func = 4'b1000; RD = 3; regwrite = 1;
        edge_then_sample();
        chk("fwd_exmem", exmem_alu, 11);

        // EX/MEM wins over MEM/WB
        @(negedge clk); nop();
        rd1 = 3; RD1 = 0; RD2 = 1; ALUop = 2'b10; func = 4'b1000; RD = 0; regwrite = 1;
        wb_regwrite = 1; wb_rd = 3; wb_data = 99;
        edge_then_sample();
        chk("fwd_priority", exmem_alu, 10);

        // x0 never forwarded
        @(negedge clk); nop();
        rd1 = 0; RD1 = 20; RD2 = 1; ALUop = 2'b10; func = 4'b1000; RD = 6; regwrite = 1;
        wb_regwrite = 1; wb_rd = 3; wb_data = 99;
        edge_then_sample();
        chk("fwd_x0", exmem_alu, 19);

        // MEM/WB forward when EX/MEM does not match
        @(negedge clk); nop();
        rd1 = 3; RD1 = 0; RD2 = 1; ALUop = 2'b10; func = 4'b1000; RD = 7; regwrite = 1;
        wb_regwrite = 1; wb_rd = 3; wb_data = 99;
        edge_then_sample();
        chk("fwd_wb", exmem_alu, 98);

        // BEQ taken
        @(negedge clk); nop();
        PC = 64'h100; Immgen = 64'h20; RD1 = 4; RD2 = 4; branch = 1; func3 = 3'b000; ALUop = 2'b01;
        edge_then_sample();
        chk("beq_flush", flush, 1);
        chk("beq_target", exmem_target, 64'h120);

        // wrong-path instruction squashed
        @(negedge clk); nop();
        RD1 = 1; RD2 = 1; RD = 9; regwrite = 1;
        edge_then_sample();
        chk("squash_flush", flush, 0);
        chk("squash_regwrite", exmem_regwrite, 0);
        chk("squash_rd", exmem_rd, 0);

        // BLT taken on -1 < 1
        @(negedge clk); nop();
        RD1 = 64'hFFFF_FFFF_FFFF_FFFF; RD2 = 1; branch = 1; func3 = 3'b100; ALUop = 2'b01;
        edge_then_sample();
        chk("blt_flush", flush, 1);
        @(negedge clk); nop();
        RD1 = 64'hFFFF_FFFF_FFFF_FFFF; RD2 = 1; branch = 1; func3 = 3'b110; ALUop = 2'b01;
        edge_then_sample();
        chk("blt_nobackto", flush, 0);

        // BLTU not taken on 0xFF..FF < 1
        @(negedge clk); nop();
        RD1 = 64'hFFFF_FFFF_FFFF_FFFF; RD2 = 1; branch = 1; func3 = 3'b110; ALUop = 2'b01;
        edge_then_sample();
        chk("bltu_flush", flush, 0);

        // stall holds contents
        @(negedge clk); nop();
        RD1 = 2; RD2 = 3; RD = 4; regwrite = 1;
        edge_then_sample();
        chk("prestall_alu", exmem_alu, 5);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); nop();
            stall = 1; RD1 = {$urandom, $urandom}; RD2 = {$urandom, $urandom};
            RD = 5'($urandom); regwrite = 1'($urandom);
            edge_then_sample();
            chk("stall_alu", exmem_alu, 5);
            chk("stall_rd", exmem_rd, 4);
            chk("stall_regwrite", exmem_regwrite, 1);
        end
        @(negedge clk); nop();
        RD1 = 10; RD2 = 20; RD = 8; regwrite = 1;
        edge_then_sample();
        chk("resume_alu", exmem_alu, 30);
        chk("resume_rd", exmem_rd, 8);

        // flush beats stall
        @(negedge clk); nop();
        PC = 64'h200; Immgen = 8; branch = 1; func3 = 3'b000; ALUop = 2'b01;
        edge_then_sample();
        chk("fs_flush", flush, 1);
        chk("fs_target", exmem_target, 64'h208);
        @(negedge clk); nop();
        stall = 1; RD1 = 1; RD2 = 1; RD = 2; regwrite = 1;
        edge_then_sample();
        chk("fs_flush_drop", flush, 0);
        chk("fs_regwrite", exmem_regwrite, 0);

        // asynchronous reset while flush is high
        @(negedge clk); nop();
        RD1 = 9; RD2 = 2; branch = 1; func3 = 3'b001; ALUop = 2'b01; PC = 64'h40; Immgen = 64'h10;
        edge_then_sample();
        chk("bne_flush", flush, 1);
        chk("bne_alu", exmem_alu, 7);
        #2 reset_n = 0;
        #1;
        chk("arst_flush", flush, 0);
        chk("arst_alu", exmem_alu, 0);
        chk("arst_target", exmem_target, 0);
        @(negedge clk); nop();
        reset_n = 1;

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            stall       = ($urandom % 6) == 0;
            branch      = ($urandom % 4) == 0;
            memwrite    = 1'($urandom);
            memread     = 1'($urandom);
            memtoreg    = 1'($urandom);
            alusrc      = 1'($urandom);
            regwrite    = 1'($urandom);
            ALUop       = 2'($urandom);
            PC          = {$urandom, $urandom};
            RD1         = pick();
            RD2         = pick();
            Immgen      = pick();
            func        = 4'($urandom);
            func3       = 3'($urandom);
            RD          = 5'($urandom % 4);
            rd1         = 5'($urandom % 4);
            rd2         = 5'($urandom % 4);
            wb_regwrite = 1'($urandom);
            wb_rd       = 5'($urandom % 4);
            wb_data     = pick();
        end
        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
